au_result_fifo: RTL
===================

AU_RESULT_FIFO -- requirements
Module: au_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of the signed arithmetic result stored per entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, the single clock (all state updates on its rising edge).
REQ-004 The block SHALL have rst input 1, a synchronous active-high reset.
REQ-005 The block SHALL have in_valid input 1, meaning the upstream arithmetic_unit result is presented this cycle.
REQ-006 The block SHALL have in_ready output 1, meaning an entry is free.
REQ-007 The block SHALL have in_q input WIDTH (signed), the result value from arithmetic_unit q.
REQ-008 The block SHALL have in_ov input 1, the overflow flag from arithmetic_unit overflow.
REQ-009 The block SHALL have in_sel input 2, the operation select that produced the result.
REQ-010 The block SHALL have out_valid output 1, meaning the head entry is available.
REQ-011 The block SHALL have out_ready input 1, meaning the consumer accepts the head entry.
REQ-012 The block SHALL have out_q output WIDTH (signed), out_ov output 1 and out_sel output 2, which together present the head entry fields.
REQ-013 The block SHALL have count output clog2(DEPTH)+1, giving the number of occupied entries.
REQ-014 The block SHALL have full output 1 and empty output 1, which are the occupancy flags.
REQ-015 The block SHALL have clr_ov input 1, a single-cycle pulse that clears the overflow statistics.
REQ-016 The block SHALL have ov_sticky output 1, which is set when any accepted entry carried in_ov=1.
REQ-017 The block SHALL have ov_count output 8, giving the number of accepted entries with in_ov=1 (see Configuration).

Function
REQ-018 A write SHALL occur on a rising edge where in_valid=1 and in_ready=1, storing {in_sel, in_ov, in_q} at the write pointer.
REQ-019 in_ready SHALL equal !full, and SHALL be independent of out_ready (no same-cycle pass-through when full).
REQ-020 A read SHALL occur on a rising edge where out_valid=1 and out_ready=1, advancing the read pointer.
REQ-021 The FIFO SHALL be show-ahead: out_valid=!empty, and out_q/out_ov/out_sel SHALL combinationally reflect the head entry.
REQ-022 Write-to-out_valid latency SHALL be exactly 1 cycle when the FIFO was empty.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL increment by 1 on a write only, decrement by 1 on a read only, and be unchanged on a simultaneous read and write.
REQ-024 full SHALL be 1 iff count==DEPTH, and empty SHALL be 1 iff count==0.
REQ-025 A simultaneous read and write when the FIFO is empty SHALL NOT occur (out_valid=0), so only the write takes effect.
REQ-026 out_q/out_ov/out_sel SHALL be don't-care while out_valid=0, but SHALL NOT be X after reset.
REQ-027 Stored data SHALL be bit-exact: there is no sign extension, saturation or modification of in_q.
REQ-028 ov_sticky SHALL be set on an accepted write with in_ov=1 and cleared by clr_ov; if both occur in the same cycle, set SHALL win.
REQ-029 Overflow entries that are not accepted (in_ready=0) SHALL NOT affect ov_sticky or ov_count.

Reset
REQ-030 While rst=1 at a clock edge, the pointers and count SHALL go to 0, ov_sticky to 0 and ov_count to 0, so that empty=1, full=0, in_ready=1, out_valid=0 and out_q/out_ov/out_sel=0.
REQ-031 A reset asserted mid-operation SHALL discard all stored entries, and any in_valid or out_ready in the reset cycle SHALL be ignored.
REQ-032 Storage array contents SHALL NOT need to be reset, but the head-entry outputs SHALL read 0 until the first write.

Configuration
REQ-033 Macro AU_RESULT_FIFO_OV_COUNT_EN SHALL compile in the 8-bit ov_count counter.
REQ-034 When AU_RESULT_FIFO_OV_COUNT_EN is defined, ov_count SHALL increment on each accepted write with in_ov=1 and saturate at 255.
REQ-035 When AU_RESULT_FIFO_OV_COUNT_EN is defined, clr_ov SHALL set ov_count to 0; if clr_ov coincides with an accepted overflow write, ov_count SHALL become 1.
REQ-036 When AU_RESULT_FIFO_OV_COUNT_EN is undefined, the port SHALL remain and ov_count SHALL be constant 0, with no counter logic.

Verification
REQ-037 The bench SHALL cover reset then fill: write q=3,-2,7,-8 (ov=0,0,1,0) with out_ready=0, giving count 1..4, full=1 and in_ready=0 after the 4th write, and ov_sticky=1.
REQ-038 The bench SHALL cover drain: out_ready=1 for 4 cycles, giving out_q=3,-2,7,-8 in order, then empty=1 and out_valid=0.
REQ-039 The bench SHALL cover simultaneous read and write at count=2 for 6 cycles, giving count steady at 2, FIFO order preserved and pointer wrap exercised.
REQ-040 The bench SHALL cover write attempted while full with in_q=5, showing the entry not stored and count staying 4.
REQ-041 The bench SHALL cover clr_ov coinciding with an accepted ov=1 write, giving ov_sticky=1, and ov_count=1 with the macro or 0 without.
REQ-042 The bench SHALL cover rst pulsed at count=3, giving count=0, empty=1 and out_valid=0 on the next cycle, with the previously stored data never emitted.

Source files
------------

// File: rtl/au_result_fifo.sv
// au_result_fifo: show-ahead FIFO buffering arithmetic_unit results
// ({sel, overflow, q} per entry), with sticky overflow tracking.
// Optional feature: define AU_RESULT_FIFO_OV_COUNT_EN to build the
// 8-bit saturating ov_count counter; otherwise ov_count is tied to 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both 1. in_ready depends only on occupancy (never on out_ready),
// and out_valid depends only on occupancy (never on in_valid).
module au_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH-1:0]   in_q,
   input  logic                      in_ov,
   input  logic [1:0]                in_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [WIDTH-1:0]   out_q,
   output logic                      out_ov,
   output logic [1:0]                out_sel,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   input  logic                      clr_ov,
   output logic                      ov_sticky,
   output logic [7:0]                ov_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = WIDTH + 3;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ov_sticky_q, ov_sticky_d;
   logic          wr_en, rd_en;
   logic [EW-1:0] head_w;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign count     = count_q;
   assign ov_sticky = ov_sticky_q;

   assign wr_en = in_valid & in_ready;
   assign rd_en = out_valid & out_ready;

   // Head entry is masked to zero while empty so outputs are never X,
   // even though the storage array itself is not reset.
   assign head_w  = empty ? '0 : mem_q[rd_ptr_q];
   assign out_q   = head_w[WIDTH-1:0];
   assign out_ov  = head_w[WIDTH];
   assign out_sel = head_w[WIDTH+2:WIDTH+1];

   // Next-state for pointers, occupancy and the sticky flag (set wins over clear).
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      ov_sticky_d = (ov_sticky_q & ~clr_ov) | (wr_en & in_ov);
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ov_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ov_sticky_q <= ov_sticky_d;
      end
   end

   // Entry storage: written bit-exact, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_ptr_q] <= {in_sel, in_ov, in_q};
   end

`ifdef AU_RESULT_FIFO_OV_COUNT_EN
   logic [7:0] ov_count_q, ov_count_d;

   // Saturating overflow counter; a coinciding clear and overflow write yields 1.
   always_comb begin
      ov_count_d = ov_count_q;
      if (wr_en && in_ov) begin
         if (clr_ov)                  ov_count_d = 8'd1;
         else if (ov_count_q != 8'hFF) ov_count_d = ov_count_q + 8'd1;
      end else if (clr_ov) begin
         ov_count_d = 8'd0;
      end
   end

   // Overflow counter register.
   always_ff @(posedge clk) begin
      if (rst) ov_count_q <= 8'd0;
      else     ov_count_q <= ov_count_d;
   end

   assign ov_count = ov_count_q;
`else
   assign ov_count = 8'd0;
`endif

endmodule
